// File: rtl/bcd_display_scanner.sv
// Two-digit BCD display scanner: double-buffered digit capture, time-multiplexed 7-segment
// drive with one-hot digit selects, leading-zero blanking and a sticky invalid-digit flag.
module bcd_display_scanner #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter bit          BLANK_LZ       = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       load,
  input  logic [3:0] bcd_units,
  input  logic [3:0] bcd_tens,
  input  logic       clr_err,
  output logic [6:0] seg,
  output logic [1:0] dig_sel,
  output logic       frame,
  output logic       err
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(SCAN_DIV - 1);

  typedef enum logic {SlotUnits, SlotTens} slot_e;

  logic [PW-1:0] presc_q, presc_d;
  slot_e         slot_q, slot_d;
  logic [3:0]    pend_units_q, pend_units_d;
  logic [3:0]    pend_tens_q, pend_tens_d;
  logic          pend_v_q, pend_v_d;
  logic [3:0]    disp_units_q, disp_units_d;
  logic [3:0]    disp_tens_q, disp_tens_d;
  logic          frame_q, frame_d;
  logic          err_q, err_d;

  logic          wrap;
  logic          boundary;
  logic          bad_digit;
  logic [6:0]    seg_raw;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h79;
    endcase
    return s;
  endfunction

  assign wrap      = ena && (presc_q == PrescMax);
  assign boundary  = wrap && (slot_q == SlotTens);
  assign bad_digit = (bcd_units > 4'd9) || (bcd_tens > 4'd9);

  always_comb begin
    presc_d      = presc_q;
    slot_d       = slot_q;
    pend_units_d = pend_units_q;
    pend_tens_d  = pend_tens_q;
    pend_v_d     = pend_v_q;
    disp_units_d = disp_units_q;
    disp_tens_d  = disp_tens_q;
    frame_d      = boundary;
    err_d        = err_q;

    if (ena) begin
      presc_d = wrap ? '0 : presc_q + 1'b1;
    end
    if (wrap) begin
      slot_d = (slot_q == SlotUnits) ? SlotTens : SlotUnits;
    end

    if (load) begin
      pend_units_d = bcd_units;
      pend_tens_d  = bcd_tens;
      pend_v_d     = 1'b1;
    end

    // A load coinciding with the boundary bypasses the pending buffer.
    if (boundary) begin
      if (load) begin
        disp_units_d = bcd_units;
        disp_tens_d  = bcd_tens;
      end else if (pend_v_q) begin
        disp_units_d = pend_units_q;
        disp_tens_d  = pend_tens_q;
      end
      pend_v_d = 1'b0;
    end

    if (clr_err) begin
      err_d = 1'b0;
    end
    if (load && bad_digit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      slot_q       <= SlotUnits;
      pend_units_q <= 4'd0;
      pend_tens_q  <= 4'd0;
      pend_v_q     <= 1'b0;
      disp_units_q <= 4'd0;
      disp_tens_q  <= 4'd0;
      frame_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      slot_q       <= slot_d;
      pend_units_q <= pend_units_d;
      pend_tens_q  <= pend_tens_d;
      pend_v_q     <= pend_v_d;
      disp_units_q <= disp_units_d;
      disp_tens_q  <= disp_tens_d;
      frame_q      <= frame_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    dig_sel = 2'b00;
    seg_raw = 7'h00;
    if (ena) begin
      if (slot_q == SlotUnits) begin
        dig_sel = 2'b01;
        seg_raw = bcd_to_seg(disp_units_q);
      end else begin
        dig_sel = 2'b10;
        if (!(BLANK_LZ && (disp_tens_q == 4'd0))) begin
          seg_raw = bcd_to_seg(disp_tens_q);
        end
      end
    end
  end

  // Polarity applied after blanking so a blank digit reads all-off on either display type.
  assign seg   = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
  assign frame = frame_q & ena;
  assign err   = err_q;

endmodule
